// File: rtl/uart_lite_pkg.sv
// Shared definitions for the uart_lite transmit and receive paths:
// transmitter state encoding and the serial line levels.
package uart_lite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period tick generator: counts 0..OVERSAMPLING-1 while enabled and flags
// the last cycle of each bit. Shared by the transmit and receive paths.
module uart_bit_timer #(
  parameter int OVERSAMPLING = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int CNT_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLING - 1);

  logic [CNT_W-1:0] tick_q;

  assign bit_end_o = en_i && (tick_q == LAST_TICK);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= '0;
    end else if (restart_i) begin
      tick_q <= '0;
    end else if (en_i) begin
      tick_q <= bit_end_o ? '0 : tick_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first, optional
// parity bit (enabled by macro UART_TX_PARITY_EN), STOP_BITS stop bits.
module uart_tx
  import uart_lite_pkg::*;
#(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  uart_tx_state_t     state_q, state_d;
  logic [DATA_BITS:0] shift_q, shift_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               tx_q, tx_d;
  logic               ready_en_q;
  logic               bit_end;
  logic               last_stop;
  logic               accept;

  // The parity bit rides above the data in the shift register, so after the
  // last data bit it sits in position 1 ready to be sent.
  function automatic logic [DATA_BITS:0] load_word(input logic [DATA_BITS-1:0] data);
    return {(^data) ^ (PARITY_ODD != 0), data};
  endfunction

  uart_bit_timer #(
    .OVERSAMPLING(OVERSAMPLING)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (state_q != IDLE),
    .restart_i(accept),
    .bit_end_o(bit_end)
  );

  assign last_stop = (state_q == STOP) && (bit_idx_q == LAST_STOP) && bit_end;
  assign ready_o   = ready_en_q && ((state_q == IDLE) || last_stop);
  assign accept    = valid_i && ready_o;
  assign busy_o    = (state_q != IDLE);
  assign tx_o      = tx_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: ;
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = shift_q[1];
`else
            state_d   = STOP;
            tx_d      = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = IDLE;
            tx_d      = UART_IDLE_LEVEL;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An accept in the last stop cycle overrides the return to IDLE.
    if (accept) begin
      state_d   = START;
      tx_d      = UART_START_LEVEL;
      shift_d   = load_word(data_i);
      bit_idx_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at OVERSAMPLING=16, 8 data bits,
// 1 stop bit; frame expectations are hand-written per build.
module tb_uart_tx;

  localparam int OS = 16;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [11:0] FRAME_55 = 12'h4AA;
  localparam logic [11:0] FRAME_A5 = 12'h54A;
  localparam logic [11:0] FRAME_3C = 12'h478;
  localparam logic [11:0] FRAME_0F = 12'h41E;
  localparam logic [11:0] FRAME_C3 = 12'h586;
`else
  localparam int NBITS = 10;
  localparam logic [11:0] FRAME_55 = 12'h2AA;
  localparam logic [11:0] FRAME_A5 = 12'h34A;
  localparam logic [11:0] FRAME_3C = 12'h278;
  localparam logic [11:0] FRAME_0F = 12'h21E;
  localparam logic [11:0] FRAME_C3 = 12'h386;
`endif

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] dataIn;
  logic       validIn;
  logic       readyOut;
  logic       txOut;
  logic       busyOut;

  int testCount = 0;
  int failCount = 0;

  logic [11:0] bits;
  logic [11:0] mids;
  int          unstable;
  int          readyCount;
  logic        readyLast;
  int          idleErrors;

  always #5 clk = ~clk;

  uart_tx #(
    .OVERSAMPLING(OS),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .data_i (dataIn),
    .valid_i(validIn),
    .ready_o(readyOut),
    .tx_o   (txOut),
    .busy_o (busyOut)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    validIn = valid;
    dataIn  = data;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame from its first start-bit cycle, recording the first and
  // mid-bit level of every bit; optionally pulses valid with 8'hFF in a window.
  task automatic captureFrame(input int nbits, input int pulseFrom, input int pulseTo,
                              output logic [11:0] firstBits, output logic [11:0] midBits,
                              output int badCycles, output int readyHits, output logic readyAtEnd);
    firstBits  = '0;
    midBits    = '0;
    badCycles  = 0;
    readyHits  = 0;
    readyAtEnd = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < OS; k++) begin
        int c;
        c = b * OS + k + 1;
        if (pulseFrom <= pulseTo) applyStimulus(c >= pulseFrom && c <= pulseTo, 8'hFF);
        if (k == 0) firstBits[b] = txOut;
        else if (txOut !== firstBits[b]) badCycles++;
        if (k == OS / 2) midBits[b] = txOut;
        if (busyOut !== 1'b1) badCycles++;
        if (readyOut === 1'b1) readyHits++;
        if (b == nbits - 1 && k == OS - 1) readyAtEnd = readyOut;
        nextCycle();
      end
    end
  endtask

  task automatic sendByte(input logic [7:0] data);
    applyStimulus(1'b1, data);
    nextCycle();
    applyStimulus(1'b0, 8'h00);
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset tx", txOut, 1);
    checkOutput("reset busy", busyOut, 0);
    checkOutput("reset ready", readyOut, 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("release ready low", readyOut, 0);
    nextCycle();
    checkOutput("release ready high", readyOut, 1);

    // Single byte
    sendByte(8'h55);
    captureFrame(NBITS, 1, 0, bits, mids, unstable, readyCount, readyLast);
    checkOutput("t1 frame", bits, FRAME_55);
    checkOutput("t1 stable", unstable, 0);
    checkOutput("t1 ready count", readyCount, 1);
    checkOutput("t1 ready last", readyLast, 1);
    checkOutput("t1 busy after", busyOut, 0);
    checkOutput("t1 tx after", txOut, 1);

    // Back-to-back: valid held, data swapped right after the first accept
    applyStimulus(1'b1, 8'hA5);
    nextCycle();
    applyStimulus(1'b1, 8'h3C);
    captureFrame(NBITS, 1, 0, bits, mids, unstable, readyCount, readyLast);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t2 frame A", bits, FRAME_A5);
    checkOutput("t2 stable A", unstable, 0);
    checkOutput("t2 ready last A", readyLast, 1);
    captureFrame(NBITS, 1, 0, bits, mids, unstable, readyCount, readyLast);
    checkOutput("t2 frame B", bits, FRAME_3C);
    checkOutput("t2 stable B", unstable, 0);
    checkOutput("t2 ready count B", readyCount, 1);
    checkOutput("t2 busy after", busyOut, 0);

    // Ignored valid pulse during cycles 20..40
    sendByte(8'h0F);
    captureFrame(NBITS, 20, 40, bits, mids, unstable, readyCount, readyLast);
    checkOutput("t3 frame", bits, FRAME_0F);
    checkOutput("t3 stable", unstable, 0);
    checkOutput("t3 ready count", readyCount, 1);
    idleErrors = 0;
    for (int i = 0; i < 40; i++) begin
      if (txOut !== 1'b1 || busyOut !== 1'b0) idleErrors++;
      nextCycle();
    end
    checkOutput("t3 no extra frame", idleErrors, 0);

    // Reset in the middle of a data bit
    sendByte(8'h00);
    repeat (40) nextCycle();
    checkOutput("t4 data low", txOut, 0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t4 async tx", txOut, 1);
    checkOutput("t4 async busy", busyOut, 0);
    checkOutput("t4 ready in reset", readyOut, 0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("t4 ready before edge", readyOut, 0);
    nextCycle();
    checkOutput("t4 ready after edge", readyOut, 1);

    // New frame after reset, also sampled mid-bit as a receiver would
    sendByte(8'hC3);
    captureFrame(NBITS, 1, 0, bits, mids, unstable, readyCount, readyLast);
    checkOutput("t5 frame", bits, FRAME_C3);
    checkOutput("t5 mid-bit", mids, FRAME_C3);
    checkOutput("t5 stable", unstable, 0);
    checkOutput("t5 busy after", busyOut, 0);

`ifdef UART_TX_PARITY_EN
    // Even parity over 8'h07 gives a parity bit of 1
    sendByte(8'h07);
    captureFrame(NBITS, 1, 0, bits, mids, unstable, readyCount, readyLast);
    checkOutput("t6 frame", bits, 12'h60E);
    checkOutput("t6 stable", unstable, 0);
    checkOutput("t6 ready last", readyLast, 1);
    checkOutput("t6 busy after", busyOut, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
